game_controller: RTL and testbench

- Top-level game-state and collision stage for the flappy-bird VGA design.
- Sits downstream of the bird and pipe renderers; consumes their per-pixel "object present" flags on the shared x/y scan.
- Detects bird/pipe overlap and ground contact, runs the IDLE/PLAY/OVER state machine, keeps a 2-digit BCD score, and drives resetGame back to the bird and pipe stages.

---
 rtl/game_controller.sv | 186 ++++++++++++++++++
 tb/tb_game_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// game_controller: game-state and collision stage for the flappy-bird VGA design.
// Watches the per-pixel bird/pipe flags on the shared x/y scan and latches any
// collision seen during a frame. It runs the IDLE/PLAY/OVER sequence, keeps a
// 2-digit BCD score, and drives resetGame back to the bird and pipe stages.
// Optional feature: define GAME_CONTROLLER_HIGH_SCORE_EN to add a persistent
// best-score register on the best_tens/best_ones outputs.
module game_controller #(
    parameter int unsigned H_MAX       = 639,
    parameter int unsigned V_MAX       = 479,
    parameter int unsigned GROUND_Y    = 440,
    parameter int unsigned OVER_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       bird_on,
    input  logic       pipe_on,
    input  logic       pipe_pass,
    output logic       resetGame,
    output logic       playing,
    output logic       gameOver,
    output logic       frame_tick,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    ,
    output logic [3:0] best_tens,
    output logic [3:0] best_ones
`endif
);

    localparam int unsigned CW = $clog2(OVER_FRAMES + 1);
    localparam logic [CW-1:0] OVER_MAX = CW'(OVER_FRAMES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          hit_q, hit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    score_tens_q, score_tens_d;
    logic [3:0]    score_ones_q, score_ones_d;
    logic          reset_game_q, reset_game_d;
    logic          playing_q, playing_d;
    logic          game_over_q, game_over_d;
    logic          frame_tick_q, frame_tick_d;
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    logic [3:0]    best_tens_q, best_tens_d;
    logic [3:0]    best_ones_q, best_ones_d;
`endif

    logic frame_end;
    logic hit_now;

    assign frame_end = (x == 10'(H_MAX)) && (y == 9'(V_MAX));
    assign hit_now   = bird_on && (pipe_on || (y >= 9'(GROUND_Y)));

    // Next-state logic for the IDLE/PLAY/OVER sequence; illegal codes fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (press) state_d = PLAY;
            end
            PLAY: begin
                if (frame_end && (hit_q || hit_now)) state_d = OVER;
            end
            OVER: begin
                if (press && (cnt_q == OVER_MAX)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Collision latch, over-frame counter and BCD score updates.
    always_comb begin
        hit_d        = hit_q;
        cnt_d        = '0;
        score_tens_d = score_tens_q;
        score_ones_d = score_ones_q;

        if ((state_q == PLAY) && hit_now) hit_d = 1'b1;
        if (frame_end)                    hit_d = 1'b0;
        if (state_d != state_q)           hit_d = 1'b0;

        if ((state_q == OVER) && (state_d == OVER)) begin
            cnt_d = cnt_q;
            if (frame_end && (cnt_q != OVER_MAX)) cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            PLAY: begin
                // A pass on the transition cycle still counts.
                if (pipe_pass) begin
                    if (score_ones_q == 4'd9) begin
                        score_ones_d = 4'd0;
                        score_tens_d = (score_tens_q == 4'd9) ? 4'd0 : score_tens_q + 4'd1;
                    end else begin
                        score_ones_d = score_ones_q + 4'd1;
                    end
                end
            end
            OVER: begin
                if (state_d == IDLE) begin
                    score_tens_d = '0;
                    score_ones_d = '0;
                end
            end
            default: begin
                score_tens_d = '0;
                score_ones_d = '0;
            end
        endcase
    end

    // Registered status outputs follow the next state so they line up with state_q.
    always_comb begin
        reset_game_d = (state_d == IDLE);
        playing_d    = (state_d == PLAY);
        game_over_d  = (state_d == OVER);
        frame_tick_d = frame_end;
    end

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    // Best score captured on entry to OVER, using the score as it lands that cycle.
    always_comb begin
        best_tens_d = best_tens_q;
        best_ones_d = best_ones_q;
        if ((state_q == PLAY) && (state_d == OVER) &&
            ({score_tens_d, score_ones_d} > {best_tens_q, best_ones_q})) begin
            best_tens_d = score_tens_d;
            best_ones_d = score_ones_d;
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hit_q        <= 1'b0;
            cnt_q        <= '0;
            score_tens_q <= '0;
            score_ones_q <= '0;
            reset_game_q <= 1'b1;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
            frame_tick_q <= 1'b0;
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
            best_tens_q  <= '0;
            best_ones_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_d;
            cnt_q        <= cnt_d;
            score_tens_q <= score_tens_d;
            score_ones_q <= score_ones_d;
            reset_game_q <= reset_game_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
            frame_tick_q <= frame_tick_d;
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
            best_tens_q  <= best_tens_d;
            best_ones_q  <= best_ones_d;
`endif
        end
    end

    assign resetGame  = reset_game_q;
    assign playing    = playing_q;
    assign gameOver   = game_over_q;
    assign frame_tick = frame_tick_q;
    assign score_tens = score_tens_q;
    assign score_ones = score_ones_q;
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    assign best_tens  = best_tens_q;
    assign best_ones  = best_ones_q;
`endif

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: self-checking bench for game_controller with a
// game-level reference model (score as an integer, frames counted).
module tb_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       press;
    logic [9:0] x;
    logic [8:0] y;
    logic       bird_on;
    logic       pipe_on;
    logic       pipe_pass;
    logic       resetGame;
    logic       playing;
    logic       gameOver;
    logic       frame_tick;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    logic [3:0] best_tens;
    logic [3:0] best_ones;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: 0=idle 1=play 2=over
    int m_state = 0;
    int m_score = 0;
    int m_best  = 0;
    int m_frames = 0;
    bit m_hit = 0;
    bit m_tick = 0;

    game_controller dut (
        .clk(clk), .reset(reset), .press(press), .x(x), .y(y),
        .bird_on(bird_on), .pipe_on(pipe_on), .pipe_pass(pipe_pass),
        .resetGame(resetGame), .playing(playing), .gameOver(gameOver),
        .frame_tick(frame_tick), .score_tens(score_tens), .score_ones(score_ones)
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        , .best_tens(best_tens), .best_ones(best_ones)
`endif
    );

    always #5 clk = ~clk;

    // One clock: apply inputs, advance the model by the game rules, settle past the edge.
    task automatic step(input bit p, input int xx, input int yy, input bit b,
                        input bit pp, input bit ps, input bit rst);
        bit fe, hit_now;
        reset = rst; press = p; x = 10'(xx); y = 9'(yy);
        bird_on = b; pipe_on = pp; pipe_pass = ps;
        @(posedge clk);
        fe = (xx == 639) && (yy == 479);
        hit_now = b && (pp || yy >= 440);
        if (rst) begin
            m_state = 0; m_score = 0; m_best = 0; m_frames = 0; m_hit = 0; m_tick = 0;
        end else begin
            m_tick = fe;
            if (m_state == 0) begin
                m_score = 0;
                if (p) m_state = 1;
            end else if (m_state == 1) begin
                if (ps) m_score = (m_score + 1) % 100;
                if (fe) begin
                    if (m_hit || hit_now) begin
                        m_state = 2;
                        m_frames = 0;
                        if (m_score > m_best) m_best = m_score;
                    end
                    m_hit = 0;
                end else if (hit_now) begin
                    m_hit = 1;
                end
            end else begin
                if (p && m_frames == 60) begin
                    m_state = 0; m_score = 0; m_frames = 0;
                end else if (fe && m_frames < 60) begin
                    m_frames++;
                end
            end
        end
        #1;
    endtask

    task automatic frame_end_step();
        step(0, 639, 479, 0, 0, 0, 0);
    endtask

    // Drive the game back to IDLE without using reset, so the best score survives.
    task automatic goto_idle();
        if (m_state == 1) step(0, 639, 479, 1, 1, 0, 0);
        if (m_state == 2) begin
            for (int i = 0; i < 60; i++) frame_end_step();
            step(1, 20, 20, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, $urandom_range(600), $urandom_range(400), 1'($urandom), 1'($urandom), 1'($urandom), 0);
            checks++;
            if ({resetGame, playing, gameOver, score_tens, score_ones} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_idle: got rg=%b pl=%b go=%b score=%h%h required 1 0 0 00",
                         resetGame, playing, gameOver, score_tens, score_ones);
            end
        end
        step(1, 5, 5, 0, 0, 0, 0);
        checks++;
        if ({playing, resetGame} !== 2'b10) begin
            errors++;
            $display("FAIL press_start: got playing=%b resetGame=%b required 1 0", playing, resetGame);
        end
    endtask

    task automatic test_score();
        for (int i = 0; i < 12; i++) step(0, 100, 100, 0, 0, 1, 0);
        checks++;
        if ({score_tens, score_ones} !== 8'h12) begin
            errors++;
            $display("FAIL score_12: got %h%h required 12", score_tens, score_ones);
        end
        for (int i = 0; i < 88; i++) step(0, 100, 100, 0, 0, 1, 0);
        checks++;
        if ({score_tens, score_ones, playing} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL score_wrap: got %h%h playing=%b required 00 1", score_tens, score_ones, playing);
        end
    endtask

    task automatic test_pipe_hit();
        for (int i = 0; i < 3; i++) step(0, 50, 60, 0, 0, 1, 0);
        step(0, 210, 300, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 300 + i, 300, 0, 0, 0, 0);
        checks++;
        if ({playing, gameOver} !== 2'b10) begin
            errors++;
            $display("FAIL hit_midframe: got playing=%b gameOver=%b required 1 0", playing, gameOver);
        end
        frame_end_step();
        checks++;
        if ({playing, gameOver, resetGame, frame_tick} !== 4'b0101) begin
            errors++;
            $display("FAIL hit_over: got pl=%b go=%b rg=%b tick=%b required 0 1 0 1",
                     playing, gameOver, resetGame, frame_tick);
        end
        for (int i = 0; i < 4; i++) step(0, 70, 70, 0, 0, 1, 0);
        checks++;
        if ({score_tens, score_ones} !== 8'h03) begin
            errors++;
            $display("FAIL score_frozen: got %h%h required 03", score_tens, score_ones);
        end
    endtask

    task automatic test_ground();
        goto_idle();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 300, 450, 1, 0, 0, 0);
        step(0, 639, 479, 0, 0, 1, 0);   // pass on the transition cycle counts
        checks++;
        if ({gameOver, score_tens, score_ones} !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL ground_450: got gameOver=%b score=%h%h required 1 01",
                     gameOver, score_tens, score_ones);
        end
        goto_idle();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 300, 439, 1, 0, 0, 0);
        frame_end_step();
        checks++;
        if ({playing, gameOver} !== 2'b10) begin
            errors++;
            $display("FAIL ground_439: got playing=%b gameOver=%b required 1 0", playing, gameOver);
        end
    endtask

    task automatic test_over_press();
        for (int i = 0; i < 5; i++) step(0, 10, 10, 0, 0, 1, 0);
        step(0, 639, 479, 1, 1, 0, 0);
        for (int i = 0; i < 30; i++) frame_end_step();
        step(1, 10, 10, 0, 0, 0, 0);
        checks++;
        if ({gameOver, resetGame} !== 2'b10) begin
            errors++;
            $display("FAIL press_30: got gameOver=%b resetGame=%b required 1 0", gameOver, resetGame);
        end
        for (int i = 0; i < 29; i++) frame_end_step();
        step(1, 639, 479, 0, 0, 0, 0);   // counter reaches 60 on this edge; press too early
        checks++;
        if (gameOver !== 1'b1) begin
            errors++;
            $display("FAIL press_59: got gameOver=%b required 1", gameOver);
        end
        step(1, 10, 10, 0, 0, 0, 0);
        checks++;
        if ({resetGame, gameOver, playing, score_tens, score_ones} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL press_60: got rg=%b go=%b pl=%b score=%h%h required 1 0 0 00",
                     resetGame, gameOver, playing, score_tens, score_ones);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 10, 10, 0, 0, 1, 0);
        checks++;
        if ({playing, score_tens, score_ones} !== {1'b1, 8'h07}) begin
            errors++;
            $display("FAIL score_07: got playing=%b score=%h%h required 1 07", playing, score_tens, score_ones);
        end
        step(0, 10, 10, 0, 0, 1, 1);
        checks++;
        if ({resetGame, playing, gameOver, score_tens, score_ones} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid: got rg=%b pl=%b go=%b score=%h%h required 1 0 0 00",
                     resetGame, playing, gameOver, score_tens, score_ones);
        end
    endtask

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    task automatic test_high_score();
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 10, 10, 0, 0, 1, 0);
        step(0, 639, 479, 1, 1, 0, 0);
        checks++;
        if ({gameOver, best_tens, best_ones} !== {1'b1, 8'h15}) begin
            errors++;
            $display("FAIL best_15: got gameOver=%b best=%h%h required 1 15", gameOver, best_tens, best_ones);
        end
        goto_idle();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 10, 10, 0, 0, 1, 0);
        goto_idle();
        checks++;
        if ({resetGame, best_tens, best_ones} !== {1'b1, 8'h15}) begin
            errors++;
            $display("FAIL best_keep: got rg=%b best=%h%h required 1 15", resetGame, best_tens, best_ones);
        end
    endtask
`endif

    task automatic test_random();
        int xx, yy;
        logic [11:0] exp_v, got_v;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) begin
                xx = 639; yy = 479;
            end else begin
                xx = $urandom_range(639); yy = $urandom_range(479);
            end
            step($urandom_range(9) == 0, xx, yy, $urandom_range(3) == 0, $urandom_range(2) == 0,
                 $urandom_range(7) == 0, $urandom_range(799) == 0);
            exp_v = {m_state == 0, m_state == 1, m_state == 2, m_tick,
                     4'(m_score / 10), 4'(m_score % 10)};
            got_v = {resetGame, playing, gameOver, frame_tick, score_tens, score_ones};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got rg/pl/go/tick/score=%h required %h", i, got_v, exp_v);
            end
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
            checks++;
            if ({best_tens, best_ones} !== {4'(m_best / 10), 4'(m_best % 10)}) begin
                errors++;
                $display("FAIL random_best%0d: got %h%h required %0d", i, best_tens, best_ones, m_best);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; press = 1'b0; x = '0; y = '0;
        bird_on = 1'b0; pipe_on = 1'b0; pipe_pass = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_score();
        test_pipe_hit();
        test_ground();
        test_over_press();
        test_reset_mid();
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        test_high_score();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
